// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// controller state enum and a size-decode helper.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        RMW_WAIT,
        RESP
    } state_t;

    // Encoding 2'b11 is an alias for a full word.
    function automatic logic is_word(input logic [1:0] size);
        return (size == SZ_W) || (size == 2'b11);
    endfunction

endpackage

// File: rtl/mem_fmt.sv
// Lane handling for the load/store unit: sub-word load extraction with
// zero/sign extension, and store-data merge into an existing RAM word.
module mem_fmt
    import mem_pkg::*;
(
    input  logic [31:0] i_ram_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte  = i_ram_word[{i_lane, 3'b000} +: 8];
        w_half  = i_ram_word[{i_lane[1], 4'b0000} +: 16];
        o_load  = i_ram_word;
        o_merge = i_wdata;
        case (i_size)
            SZ_B: begin
                o_load  = {{24{i_signed & w_byte[7]}}, w_byte};
                o_merge = i_ram_word;
                o_merge[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_H: begin
                o_load  = {{16{i_signed & w_half[15]}}, w_half};
                o_merge = i_ram_word;
                o_merge[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_unit.sv
// CPU load/store unit in front of a one-cycle-latency synchronous block RAM.
// Define MEM_UNIT_MISALIGN_CHK_EN to report misaligned half/word accesses via resp_err.
module mem_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_di,
    input  logic [31:0] ram_dout
);

    state_t              r_state;
    logic                r_ready;
    logic                r_resp_valid;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_lane;
    logic [1:0]          r_size;
    logic                r_signed;
    logic [31:0]         r_wdata;

    logic                w_accept;
    logic                w_misalign;
    logic                w_word_store;
    logic [ADDR_W-1:0]   w_word_addr;
    logic [31:0]         w_load;
    logic [31:0]         w_merge;
    logic                w_unused;

`ifdef MEM_UNIT_MISALIGN_CHK_EN
    assign w_misalign = ((req_size == SZ_H) && req_addr[0]) ||
                        (is_word(req_size) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_accept     = req_valid & r_ready;
    assign w_word_store = w_accept & req_we & is_word(req_size) & ~w_misalign;
    assign w_unused     = ^req_addr;

    mem_fmt u_fmt (
        .i_ram_word (ram_dout),
        .i_wdata    (r_wdata),
        .i_lane     (r_lane),
        .i_size     (r_size),
        .i_signed   (r_signed),
        .o_load     (w_load),
        .o_merge    (w_merge)
    );

    // In IDLE the RAM must see the live request address so the read (or the
    // full-word write) happens on the acceptance edge itself.
    always_comb begin
        w_word_addr = r_addr;
        ram_we      = 1'b0;
        ram_di      = w_merge;
        if (r_state == IDLE) begin
            w_word_addr = req_addr[ADDR_W+1:2];
            ram_we      = w_word_store;
            ram_di      = req_wdata;
        end else if (r_state == RMW_WAIT) begin
            ram_we      = 1'b1;
        end
    end

    assign ram_addr   = {30'(w_word_addr), 2'b00};
    assign req_ready  = r_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_ready      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_lane       <= '0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_wdata      <= '0;
        end else begin
            r_ready      <= 1'b0;
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr   <= req_addr[ADDR_W+1:2];
                        r_lane   <= req_addr[1:0];
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_wdata  <= req_wdata;
                        r_err    <= 1'b0;
                        r_rdata  <= '0;
                        if (w_misalign) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_err        <= 1'b1;
                        end else if (req_we && is_word(req_size)) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                        end else if (req_we) begin
                            r_state <= RMW_WAIT;
                        end else begin
                            r_state <= LOAD_WAIT;
                        end
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                LOAD_WAIT: begin
                    r_rdata      <= w_load;
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                end
                RMW_WAIT: begin
                    r_rdata      <= '0;
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                end
                RESP: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit: directed vector table, reset-during-RMW
// sequence and randomized traffic against a byte-level memory model.
module tb_mem_unit;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_di;
    logic [31:0] ram_dout;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] tb_ram  [0:255];
    logic [31:0] ref_mem [0:255];
    logic        clr_mem;

    mem_unit #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_di     (ram_di),
        .ram_dout   (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM, one cycle read latency, read-before-write.
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 256; i++) tb_ram[i] <= '0;
            ram_dout <= '0;
        end else begin
            if (ram_we) tb_ram[ram_addr[9:2]] <= ram_di;
            ram_dout <= tb_ram[ram_addr[9:2]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level reference: memory as bytes, accesses as byte runs.
    function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rd, output logic err,
                                  output int lat, output int wes);
        int nb;
        int off;
        int widx;
        logic [31:0] word;
        nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off  = int'(addr[1:0]);
        widx = int'(addr[9:2]);
        word = ref_mem[widx];
        rd   = '0;
        err  = 1'b0;
        lat  = 2;
        wes  = 0;
`ifdef MEM_UNIT_MISALIGN_CHK_EN
        if ((off % nb) != 0) begin
            err = 1'b1;
            lat = 1;
        end
`endif
        off = off - (off % nb);
        if (err) begin
            rd = '0;
        end else if (we) begin
            for (int k = 0; k < nb; k++) word[8*(off+k) +: 8] = wdata[8*k +: 8];
            ref_mem[widx] = word;
            wes = 1;
            lat = (nb == 4) ? 1 : 2;
        end else begin
            for (int k = 0; k < nb; k++) rd[8*k +: 8] = word[8*(off+k) +: 8];
            if (sgn && nb < 4 && rd[8*nb-1])
                for (int k = nb; k < 4; k++) rd[8*k +: 8] = 8'hFF;
        end
    endfunction

    task automatic run_txn(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input logic exp_err,
                           input int exp_lat, input int exp_wes, input string tag);
        int n;
        int lat;
        int wes;
        logic got;
        logic [31:0] rd;
        logic er;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        #1;
        wes = int'(ram_we);
        chk({tag, " ram_addr"}, ram_addr, addr & 32'h0000_03FC);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = $urandom_range(0, 1);
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 0;
        got = 1'b0;
        rd  = '0;
        er  = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk({tag, " busy"}, {31'd0, req_ready}, 32'd0);
            wes += int'(ram_we);
            if (resp_valid) begin
                got = 1'b1;
                rd  = resp_rdata;
                er  = resp_err;
            end
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " rdata"}, rd, exp_rd);
        chk({tag, " err"}, {31'd0, er}, {31'd0, exp_err});
        chk({tag, " ram_we count"}, wes, exp_wes);
        @(negedge clk);
        chk({tag, " ready after resp"}, {31'd0, req_ready}, 32'd1);
        chk({tag, " resp pulse"}, {31'd0, resp_valid}, 32'd0);
    endtask

    task automatic model_txn(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        logic [31:0] rd;
        logic er;
        int lat;
        int wes;
        model(we, size, sgn, addr, wdata, rd, er, lat, wes);
        run_txn(we, size, sgn, addr, wdata, rd, er, lat, wes, tag);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_wes;
    } vec_t;

    vec_t vecs[13];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d_rd;
        logic        d_er;
        int          d_lat;
        int          d_wes;

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1, 1};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0};
        vecs[2]  = '{1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 1, 1};
        vecs[3]  = '{1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA, 32'h0, 1'b0, 2, 1};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h1122AA44, 1'b0, 2, 0};
        vecs[5]  = '{1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0};
        vecs[6]  = '{1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 32'h000000AA, 1'b0, 2, 0};
        vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, 32'h0, 1'b0, 2, 1};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h8001AA44, 1'b0, 2, 0};
        vecs[9]  = '{1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, 2, 0};
        vecs[10] = '{1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 32'h00008001, 1'b0, 2, 0};
`ifdef MEM_UNIT_MISALIGN_CHK_EN
        vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0};
`else
        vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0};
`endif
        vecs[12] = '{1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 32'h8001AA44, 1'b0, 2, 0};

        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        clr_mem    = 1'b1;
        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;

        repeat (3) @(negedge clk);
        chk("reset ready", {31'd0, req_ready}, 32'd0);
        chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset rdata", resp_rdata, 32'd0);
        chk("reset err", {31'd0, resp_err}, 32'd0);
        chk("reset ram_we", {31'd0, ram_we}, 32'd0);
        clr_mem = 1'b0;
        rstn    = 1'b1;
        @(posedge clk);
        #1;
        chk("ready after reset", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            model(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                  d_rd, d_er, d_lat, d_wes);
            run_txn(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_wes,
                    $sformatf("vec%0d", i));
        end

        // Reset while the byte-store read-modify-write is pending.
        model_txn(1'b1, 2'd2, 1'b0, 32'h30, 32'h55667788, "rst prep");
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd0;
        req_addr  = 32'h31;
        req_wdata = 32'h00000000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("rmw rst ram_we", {31'd0, ram_we}, 32'd0);
        chk("rmw rst ready", {31'd0, req_ready}, 32'd0);
        chk("rmw rst resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("rmw rst ram_we hold", {31'd0, ram_we}, 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rmw rst ready release", {31'd0, req_ready}, 32'd1);
        chk("rmw rst mem intact", tb_ram[12], 32'h55667788);
        run_txn(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'h55667788, 1'b0, 2, 0, "rmw rst reload");

        for (int i = 0; i < 120; i++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 255));
            model_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      a, $urandom, $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        for (int i = 0; i < 256; i++) chk($sformatf("mem[%0d]", i), tb_ram[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_unit.md
MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning RAM word-address bits; ram_addr bits above ADDR_W+1 are driven 0.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  CPU load/store request.
REQ-005 SHALL have port req_ready  output  1  unit idle, request accepted when req_valid&req_ready at a rising edge.
REQ-006 SHALL have port req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 SHALL have port req_signed  input  1  sign-extend sub-word loads.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse, no back-pressure.
REQ-012 SHALL have port resp_rdata  output  32  load result, 0 for stores.
REQ-013 SHALL have port resp_err  output  1  misaligned access (macro only, else tied 0).
REQ-014 SHALL have ports ram_we output 1, ram_addr output 32 (word-aligned byte address), ram_di output 32, ram_dout input 32 to the one-cycle-latency synchronous block RAM.

Function
REQ-015 SHALL use FSM states IDLE, LOAD_WAIT, RMW_WAIT, RESP; req_ready=1 only in IDLE.
REQ-016 SHALL, in IDLE, drive ram_addr={req_addr[31:2],2'b00} combinationally so the RAM samples it at the acceptance edge.
REQ-017 Load: IDLE->LOAD_WAIT; in LOAD_WAIT register formatted ram_dout; ->RESP; resp_valid 2 cycles after acceptance edge.
REQ-018 Word store: ram_we=1, ram_di=req_wdata combinationally in the accepting IDLE cycle; IDLE->RESP; resp_valid 1 cycle after acceptance.
REQ-019 Byte/half store: read at acceptance; RMW_WAIT drives registered address, ram_we=1, ram_di=ram_dout with addressed lanes replaced; ->RESP; resp_valid 2 cycles after acceptance.
REQ-020 SHALL use little-endian lanes: byte lane addr[1:0] (lane 0 = bits 7:0), half lane addr[1] (0 = bits 15:0).
REQ-021 Sub-word loads SHALL zero-extend when req_signed=0, sign-extend from bit 7/15 when 1.
REQ-022 RESP SHALL last exactly one cycle then return to IDLE; next request accepted the cycle after RESP.
REQ-023 ram_we SHALL be 0 in every state/cycle not named in REQ-018/REQ-019.

Reset
REQ-024 rstn low SHALL immediately force state IDLE, resp_valid=0, resp_rdata=0, resp_err=0, ram_we=0, req_ready=0 while rstn low; in-flight request discarded, no partial RMW write.
REQ-025 req_ready SHALL rise the first cycle after rstn deasserts.

Configuration
REQ-026 With MEM_UNIT_MISALIGN_CHK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL go IDLE->RESP with resp_err=1, resp_rdata=0, no RAM write.
REQ-027 Without it: misaligned low bits SHALL be ignored (half uses addr[1] only, word ignores addr[1:0]); resp_err tied 0.

Structure
REQ-028 Package mem_pkg SHALL hold size encodings SZ_B/SZ_H/SZ_W and the FSM state enum.
REQ-029 Combinational sub-module mem_fmt SHALL hold load extraction/extension and store lane merge.

Verification
REQ-030 Word store 0xDEADBEEF @0x10, word load @0x10 -> ram_we pulse 1 cycle; resp_rdata=0xDEADBEEF 2 cycles after acceptance.
REQ-031 Word 0x11223344 at 0x20; store byte 0xAA @0x21 -> word becomes 0x1122AA44; signed byte load @0x21 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
REQ-032 Half store 0x8001 @0x22 over 0x1122AA44 -> 0x8001AA44; signed half load @0x22 -> 0xFFFF8001.
REQ-033 With macro, word load @0x13 -> resp_err=1, resp_rdata=0, 1-cycle latency, no ram_we; without macro -> reads word @0x10.
REQ-034 rstn low during RMW_WAIT of byte store -> no ram_we, memory word unchanged, req_ready=1 first cycle after release.
